// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: brings spi_rx bytes and cs into the clk domain and decodes
// cs-framed opcode/data transactions into register-bus strobes.
module spi_cmd_decoder #(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [WIDTH-1:0]  command_byte,
  input  logic              byte_ready,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [WIDTH-1:0]  reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  output logic              clr_pulse,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        err_count
);
  typedef enum logic [1:0] {IDLE, OPCODE, DATA, DONE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, br_sync_q, br_sync_d;
  logic br_prev_q, br_prev_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic we_q, we_d, re_q, re_d, clr_q, clr_d, ferr_q, ferr_d;
  logic [7:0] cnt_q, cnt_d;
  logic cs_s, byte_evt;
  logic [1:0] cmd;
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign byte_evt = br_sync_q[SYNC_STAGES-1] & ~br_prev_q;
  assign cmd      = command_byte[WIDTH-1 -: 2];
  always_comb begin
    cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], cs};
    br_sync_d = {br_sync_q[SYNC_STAGES-2:0], byte_ready};
    br_prev_d = br_sync_q[SYNC_STAGES-1];
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    clr_d     = 1'b0;
    ferr_d    = ferr_q;
    cnt_d     = cnt_q;
    // cs release takes priority over any byte arriving in the same cycle
    if (cs_s) begin
      state_d = IDLE;
      if (state_q == DATA) begin
        ferr_d = 1'b1;
        cnt_d  = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
      end
    end else begin
      case (state_q)
        IDLE:   state_d = OPCODE;
        OPCODE: if (byte_evt) begin
          case (cmd)
            2'b01: begin
              addr_d  = command_byte[ADDR_W-1:0];
              state_d = DATA;
            end
            2'b10: begin
              addr_d  = command_byte[ADDR_W-1:0];
              re_d    = 1'b1;
              state_d = DONE;
            end
            2'b11: begin
              clr_d   = 1'b1;
              ferr_d  = 1'b0;
              cnt_d   = 8'd0;
              state_d = DONE;
            end
            default: state_d = OPCODE;
          endcase
        end
        DATA: if (byte_evt) begin
          wdata_d = command_byte;
          we_d    = 1'b1;
          state_d = DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cs_sync_q <= '1;
      br_sync_q <= '0;
      br_prev_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      clr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      cs_sync_q <= cs_sync_d;
      br_sync_q <= br_sync_d;
      br_prev_q <= br_prev_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      clr_q     <= clr_d;
      ferr_q    <= ferr_d;
      cnt_q     <= cnt_d;
    end
  end
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign clr_pulse = clr_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = ferr_q;
  assign err_count = cnt_q;
endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
Downstream stage of spi_rx. It takes each received byte (command_byte / byte_ready, both produced in the sclk domain) together with the raw cs line, and moves them into the system clock domain. It parses each cs-framed transaction as opcode plus optional data byte and drives a simple register-bus strobe interface toward the register file. It also tracks truncated frames with a sticky flag and a saturating error counter.

Parameters:
WIDTH, 8, byte width; must match spi_rx WIDTH
ADDR_W, 4, register address width, taken from opcode bits [ADDR_W-1:0]
SYNC_STAGES, 2, flip-flop depth of the cs/byte_ready synchronizers (min 2)

Ports:
clk  input  1  system clock; all logic in this block is clocked on its rising edge
rst  input  1  reset, asynchronous, active-high
cs  input  1  raw SPI chip select (active low, asynchronous to clk)
command_byte  input  WIDTH  byte from spi_rx; held stable until the next byte completes
byte_ready  input  1  spi_rx byte-complete flag (sclk domain, asynchronous to clk)
reg_addr  output  ADDR_W  register address for reg_we/reg_re
reg_wdata  output  WIDTH  write data, valid with reg_we
reg_we  output  1  one-cycle write strobe
reg_re  output  1  one-cycle read-request strobe
clr_pulse  output  1  one-cycle clear-all-registers strobe
busy  output  1  high while a frame is open (state != IDLE)
frame_err  output  1  sticky: a write frame was truncated
err_count  output  8  saturating count of truncated frames

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; byte_ready sync chain=0; cs sync chain=1, so no false frame start on release. Reset mid-frame aborts silently: no strobe, no error count.
- Sync: cs and byte_ready each pass through SYNC_STAGES flops. byte_evt = rising edge of synced byte_ready (1-cycle pulse). cs_s = synced cs.
- On the byte_evt cycle, command_byte is sampled directly. Upstream contract: it is stable for at least SYNC_STAGES+2 clk cycles after byte_ready rises.
- Opcode byte: bits[7:6] = cmd (00 NOP, 01 WRITE, 10 READ, 11 CLEAR); bits[ADDR_W-1:0] = address; the remaining bits are ignored.
- State machine:
  - IDLE: cs_s=0 -> OPCODE.
  - OPCODE, on byte_evt by cmd:
    - NOP: stay in OPCODE (padding allowed).
    - WRITE: latch reg_addr -> DATA.
    - READ: reg_addr=addr, reg_re=1 for one cycle -> DONE.
    - CLEAR: clr_pulse=1 for one cycle; frame_err=0, err_count=0 -> DONE.
  - DATA: on byte_evt, reg_wdata=byte and reg_we=1 for one cycle -> DONE.
  - DONE: further bytes are ignored with no strobes and no error.
  - Any state, cs_s=1 -> IDLE. If leaving DATA this way: frame_err=1 and err_count+=1, saturating at 255.
- Latency: all strobes are registered and assert exactly 1 cycle after the byte_evt cycle. From the raw byte_ready rise the total is at most SYNC_STAGES+2 clk edges.
- Simultaneous events:
  - byte_evt and cs_s rising in the same cycle: cs wins, the byte is discarded, and the DATA-truncation rule still applies.
  - CLEAR arriving while err_count is saturated: CLEAR wins and sets the count to 0.
- reg_addr and reg_wdata hold their last values between strobes.
- At most one of reg_we, reg_re, clr_pulse is high in any cycle.
- busy=0 only in IDLE.
- A new frame requires cs_s high for at least 1 cycle (back to IDLE) before it goes low again.

Test Plan:
1. cs low; send 0x43 then 0x5A; cs high -> one reg_we pulse with reg_addr=3, reg_wdata=0x5A; frame_err=0, busy returns 0.
2. Send frame with bytes 0x00, 0x00, 0x8C -> NOPs are skipped; one reg_re pulse with reg_addr=0xC; no reg_we.
3. Send 0x47, then raise cs before a data byte -> no reg_we; frame_err=1, err_count=1. Next frame sends 0xC0 -> clr_pulse for 1 cycle; frame_err=0, err_count=0.
4. Send 0x41, 0x11, 0x22, 0x33 in one frame -> a single reg_we with wdata=0x11; the extra bytes are ignored.
5. Run 260 truncated write frames -> err_count stops at 255 and does not wrap.
6. Assert rst in the middle of a frame, between the opcode and data bytes -> all outputs 0 at once; after release, the next complete frame 0x42/0x99 writes normally; err_count stays 0.
